// File: rtl/button_pulse_conditioner.sv
// Push-button front end for the PWM duty stage: synchronise, debounce, and turn
// button presses into single-cycle inc/dec step pulses with auto-repeat and a both-pressed lockout.
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic inc_level,
    output logic dec_level,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic locked
);

    typedef enum logic [1:0] {IDLE, FIRST, REPEAT, LOCK} state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_CNT  = CNT_W'(REPEAT_RATE);

    // Bit 0 is the increase button, bit 1 the decrease button throughout.
    logic [1:0]       raw;
    logic [1:0]       sync_q1;
    logic [1:0]       sync_q2;
    logic [1:0]       level;
    logic [1:0]       level_d;
    logic [1:0]       press;
    logic [CNT_W-1:0] db_cnt [2];

    state_t           state;
    state_t           state_nxt;
    logic             act;
    logic             act_nxt;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_cnt_nxt;
    logic [CNT_W-1:0] rep_cnt_inc;
    logic             fire;
    logic             inc_pulse_nxt;
    logic             dec_pulse_nxt;

    assign raw = {btn_dec_raw, btn_inc_raw};

    // A level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= '0;
            sync_q2   <= '0;
            level     <= '0;
            level_d   <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            level_d <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync_q2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press       = level & ~level_d;
    assign rep_cnt_inc = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            act       <= 1'b0;
            rep_cnt   <= '0;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            act       <= act_nxt;
            rep_cnt   <= rep_cnt_nxt;
            inc_pulse <= inc_pulse_nxt;
            dec_pulse <= dec_pulse_nxt;
        end
    end

    // Release is tested before the repeat timer so a release always beats a due pulse.
    always_comb begin
        state_nxt   = state;
        act_nxt     = act;
        rep_cnt_nxt = rep_cnt_inc;
        fire        = 1'b0;
        if (!ena) begin
            state_nxt   = IDLE;
            rep_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    rep_cnt_nxt = '0;
                    if (press[0] && !level[1]) begin
                        fire      = 1'b1;
                        act_nxt   = 1'b0;
                        state_nxt = FIRST;
                    end else if (press[1] && !level[0]) begin
                        fire      = 1'b1;
                        act_nxt   = 1'b1;
                        state_nxt = FIRST;
                    end else if (|press) begin
                        state_nxt = LOCK;
                    end
                end
                FIRST: begin
                    if (!level[act]) begin
                        state_nxt = IDLE;
                    end else if (level[~act]) begin
                        state_nxt = LOCK;
                    end else if ((REPEAT_RATE != 0) && (rep_cnt >= DELAY_CNT)) begin
                        fire      = 1'b1;
                        state_nxt = REPEAT;
                    end
                end
                REPEAT: begin
                    if (!level[act]) begin
                        state_nxt = IDLE;
                    end else if (level[~act]) begin
                        state_nxt = LOCK;
                    end else if (rep_cnt >= RATE_CNT) begin
                        fire = 1'b1;
                    end
                end
                LOCK: begin
                    rep_cnt_nxt = '0;
                    if (level == 2'b00) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (fire) begin
                rep_cnt_nxt = CNT_W'(1);
            end
        end
        inc_pulse_nxt = fire && !act_nxt;
        dec_pulse_nxt = fire && act_nxt;
    end

    assign inc_level = level[0];
    assign dec_level = level[1];
    assign locked    = (state == LOCK) && ena;

endmodule
